// File: rtl/ahb_params_pkg.sv
// Shared AHB-Lite encodings plus responder FSM state type and the little-endian lane-mask helper.
package ahb_params_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE      = 3'b000;
  localparam logic [2:0] HSIZE_HALF_WORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } ahb_slv_state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE:      mask = 4'b0001 << offs;
      HSIZE_HALF_WORD: mask = 4'b0011 << offs;
      default:         mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_mem_slave_array.sv
// Word-organised storage with per-byte write enables; combinational read, no reset.
module ahb_mem_slave_array #(
  parameter int unsigned Depth     = 256,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder: per-beat programmable wait states and a two-cycle ERROR response.
module ahb_mem_slave
  import ahb_params_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned AW       = $clog2(MEM_DEPTH);
  localparam int unsigned WaitInit = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  ahb_slv_state_t  state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [3:0]      mask_q, mask_d;

  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  accept, xfer_err;
  logic                  mem_we;
  logic [31:0]           mem_rdata;
  logic                  unused_ok;

  assign unused_ok = ^{HBURST, HTRANS[0]};
  assign word_idx  = HADDR[ADDR_WIDTH-1:2];
  assign accept    = HSEL & HREADY & HTRANS[1];

  always_comb begin
    xfer_err = 1'b0;
    if (HSIZE > HSIZE_WORD) xfer_err = 1'b1;
    if (HSIZE == HSIZE_HALF_WORD && HADDR[0]) xfer_err = 1'b1;
    if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) xfer_err = 1'b1;
    if (word_idx >= (ADDR_WIDTH-2)'(MEM_DEPTH)) xfer_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    mask_d  = mask_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all present HREADYOUT high, so each may take a pipelined accept.
        state_d = S_IDLE;
        if (accept) begin
          addr_d  = HADDR[AW+1:2];
          write_d = HWRITE;
          mask_d  = lane_mask(HSIZE, HADDR[1:0]);
          if (xfer_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WaitInit);
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      mask_q  <= mask_d;
    end
  end

  assign mem_we    = (state_q == S_DATA) && write_q;
  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = ((state_q == S_DATA) && !write_q) ? mem_rdata : '0;

  ahb_mem_slave_array #(
    .Depth    (MEM_DEPTH),
    .AddrWidth(AW)
  ) u_array (
    .clk_i  (HCLK),
    .we_i   (mem_we),
    .addr_i (addr_q),
    .be_i   (mask_q),
    .wdata_i(HWDATA),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: three responders (0, 2 and 3 wait states) share one bus; sel picks the target.
module tb_ahb_mem_slave;
  import ahb_params_pkg::*;

  localparam int MaxItems = 12;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel_bus;
  logic [1:0]  sel;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        resp_m;
  logic [31:0] rdata_m;

  logic        hsel_v  [3];
  logic        ready_v [3];
  logic        resp_v  [3];
  logic [31:0] rdata_v [3];

  always #5 HCLK = ~HCLK;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign hsel_v[k] = hsel_bus && (sel == 2'(k));
    ahb_mem_slave #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .MEM_DEPTH  (256),
      .WAIT_STATES((k == 0) ? 0 : k + 1)
    ) u_dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .HSEL     (hsel_v[k]),
      .HADDR    (HADDR),
      .HTRANS   (HTRANS),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HBURST   (HBURST),
      .HWDATA   (HWDATA),
      .HREADY   (HREADY),
      .HRDATA   (rdata_v[k]),
      .HREADYOUT(ready_v[k]),
      .HRESP    (resp_v[k])
    );
  end

  assign HREADY  = ready_v[sel];
  assign resp_m  = resp_v[sel];
  assign rdata_m = rdata_v[sel];

  logic [1:0]  it_trans [MaxItems];
  logic        it_wr    [MaxItems];
  logic [31:0] it_addr  [MaxItems];
  logic [2:0]  it_size  [MaxItems];
  logic [31:0] it_wdata [MaxItems];
  logic [31:0] ob_rdata   [MaxItems];
  logic        ob_resp    [MaxItems];
  logic        ob_lowresp [MaxItems];
  int          ob_waits   [MaxItems];

  int passed = 0;
  int total  = 0;

  task automatic set_item(input int i, input logic [1:0] tr, input logic wr,
                          input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    it_trans[i] = tr;
    it_wr[i]    = wr;
    it_addr[i]  = a;
    it_size[i]  = sz;
    it_wdata[i] = d;
  endtask

  // Waits out the data phase of item p (if any), recording its low cycles and final response.
  task automatic finish_prev(input int p);
    int   w = 0;
    logic lr = 1'b0;
    while (HREADY !== 1'b1 && w < 40) begin
      lr = lr | resp_m;
      w++;
      @(posedge HCLK); #1;
    end
    if (w >= 40) begin
      total++;
      $display("FAIL ready_timeout: item %0d HREADYOUT stuck low for %0d cycles, want <40", p, w);
    end
    if (p >= 0) begin
      ob_waits[p]   = w;
      ob_lowresp[p] = lr;
      ob_resp[p]    = resp_m;
      ob_rdata[p]   = rdata_m;
    end
  endtask

  // Issues items as a pipelined sequence: next address phase overlaps the current data phase.
  task automatic run_seq(input int n);
    int prev = -1;
    for (int i = 0; i < n; i++) begin
      hsel_bus = 1'b1;
      HTRANS   = it_trans[i];
      HADDR    = it_addr[i];
      HWRITE   = it_wr[i];
      HSIZE    = it_size[i];
      finish_prev(prev);
      @(posedge HCLK); #1;
      if (it_wr[i] && it_trans[i][1]) HWDATA = it_wdata[i];
      prev = i;
    end
    HTRANS = HTRANS_IDLE;
    finish_prev(prev);
  endtask

  task automatic idle_cycles(input int n);
    HTRANS = HTRANS_IDLE;
    repeat (n) begin
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ready_v[k] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", k, ready_v[k]);
      else passed++;
      total++;
      if (resp_v[k] !== 1'b0) $display("FAIL reset_resp[%0d]: got %b want 0", k, resp_v[k]);
      else passed++;
      total++;
      if (rdata_v[k] !== 32'h0) $display("FAIL reset_rdata[%0d]: got %h want 0", k, rdata_v[k]);
      else passed++;
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    idle_cycles(1);
  endtask

  task automatic test_basic();
    sel = 2'd0;
    HBURST = HBURST_SINGLE;
    set_item(0, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF);
    set_item(1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
    run_seq(2);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (ob_waits[i] !== 0) $display("FAIL basic_waits[%0d]: got %0d want 0", i, ob_waits[i]);
      else passed++;
      total++;
      if (ob_resp[i] !== 1'b0) $display("FAIL basic_resp[%0d]: got %b want 0", i, ob_resp[i]);
      else passed++;
    end
    total++;
    if (ob_rdata[0] !== 32'h0) $display("FAIL basic_wr_rdata: got %h want 0", ob_rdata[0]);
    else passed++;
    total++;
    if (ob_rdata[1] !== 32'hDEAD_BEEF)
      $display("FAIL basic_rd: got %h want deadbeef", ob_rdata[1]);
    else passed++;
    idle_cycles(1);
  endtask

  task automatic test_byte_lanes();
    sel = 2'd0;
    set_item(0, HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD,      32'h1122_3344);
    set_item(1, HTRANS_NONSEQ, 1'b1, 32'h21, HSIZE_BYTE,      32'h5555_AA55);
    set_item(2, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD,      32'h0);
    set_item(3, HTRANS_NONSEQ, 1'b1, 32'h22, HSIZE_HALF_WORD, 32'hBEEF_1234);
    set_item(4, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD,      32'h0);
    set_item(5, HTRANS_NONSEQ, 1'b0, 32'h23, HSIZE_BYTE,      32'h0);
    run_seq(6);
    total++;
    if (ob_rdata[2] !== 32'h1122_AA44) $display("FAIL byte_wr: got %h want 1122aa44", ob_rdata[2]);
    else passed++;
    total++;
    if (ob_rdata[4] !== 32'hBEEF_AA44) $display("FAIL half_wr: got %h want beefaa44", ob_rdata[4]);
    else passed++;
    total++;
    if (ob_rdata[5] !== 32'hBEEF_AA44)
      $display("FAIL byte_rd_word: got %h want beefaa44", ob_rdata[5]);
    else passed++;
    idle_cycles(1);
  endtask

  task automatic test_wait_burst();
    sel = 2'd1;
    HBURST = HBURST_INCR4;
    for (int i = 0; i < 4; i++) begin
      set_item(i, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, 32'h40 + 32'(4 * i), HSIZE_WORD,
               32'hA5A5_0000 + 32'(i * 16 + 1));
      set_item(i + 4, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, 32'h40 + 32'(4 * i),
               HSIZE_WORD, 32'h0);
    end
    run_seq(8);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ob_waits[i] !== 2) $display("FAIL ws2_waits[%0d]: got %0d want 2", i, ob_waits[i]);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ob_rdata[i + 4] !== 32'hA5A5_0000 + 32'(i * 16 + 1))
        $display("FAIL ws2_rd[%0d]: got %h want %h", i, ob_rdata[i + 4],
                 32'hA5A5_0000 + 32'(i * 16 + 1));
      else passed++;
    end
    idle_cycles(1);
  endtask

  task automatic test_error();
    sel = 2'd0;
    HBURST = HBURST_SINGLE;
    set_item(0, HTRANS_NONSEQ, 1'b1, 32'h000, HSIZE_WORD,      32'hCAFE_F00D);
    set_item(1, HTRANS_NONSEQ, 1'b0, 32'h002, HSIZE_WORD,      32'h0);
    set_item(2, HTRANS_NONSEQ, 1'b0, 32'h400, HSIZE_WORD,      32'h0);
    set_item(3, HTRANS_NONSEQ, 1'b1, 32'h002, HSIZE_WORD,      32'h1234_5678);
    set_item(4, HTRANS_NONSEQ, 1'b1, 32'h400, HSIZE_WORD,      32'h8765_4321);
    set_item(5, HTRANS_NONSEQ, 1'b1, 32'h001, HSIZE_HALF_WORD, 32'h5A5A_5A5A);
    set_item(6, HTRANS_NONSEQ, 1'b1, 32'h000, 3'b011,          32'h0F0F_0F0F);
    set_item(7, HTRANS_NONSEQ, 1'b0, 32'h000, HSIZE_WORD,      32'h0);
    run_seq(8);
    for (int i = 1; i < 7; i++) begin
      total++;
      if (ob_waits[i] !== 1) $display("FAIL err_waits[%0d]: got %0d want 1", i, ob_waits[i]);
      else passed++;
      total++;
      if (ob_lowresp[i] !== 1'b1)
        $display("FAIL err_resp1[%0d]: got %b want 1", i, ob_lowresp[i]);
      else passed++;
      total++;
      if (ob_resp[i] !== 1'b1) $display("FAIL err_resp2[%0d]: got %b want 1", i, ob_resp[i]);
      else passed++;
    end
    total++;
    if (ob_rdata[1] !== 32'h0) $display("FAIL err_rdata: got %h want 0", ob_rdata[1]);
    else passed++;
    total++;
    if (ob_resp[7] !== 1'b0) $display("FAIL err_after_resp: got %b want 0", ob_resp[7]);
    else passed++;
    total++;
    if (ob_rdata[7] !== 32'hCAFE_F00D)
      $display("FAIL err_mem_kept: got %h want cafef00d", ob_rdata[7]);
    else passed++;
    idle_cycles(1);
  endtask

  task automatic test_busy();
    sel = 2'd1;
    HBURST = HBURST_INCR;
    set_item(0, HTRANS_NONSEQ, 1'b1, 32'h80, HSIZE_WORD, 32'hB0B0_0001);
    set_item(1, HTRANS_BUSY,   1'b1, 32'h84, HSIZE_WORD, 32'h0);
    set_item(2, HTRANS_SEQ,    1'b1, 32'h84, HSIZE_WORD, 32'hB0B0_0002);
    set_item(3, HTRANS_BUSY,   1'b1, 32'h88, HSIZE_WORD, 32'h0);
    set_item(4, HTRANS_SEQ,    1'b1, 32'h88, HSIZE_WORD, 32'hB0B0_0003);
    set_item(5, HTRANS_NONSEQ, 1'b0, 32'h80, HSIZE_WORD, 32'h0);
    set_item(6, HTRANS_SEQ,    1'b0, 32'h84, HSIZE_WORD, 32'h0);
    set_item(7, HTRANS_BUSY,   1'b0, 32'h88, HSIZE_WORD, 32'h0);
    set_item(8, HTRANS_SEQ,    1'b0, 32'h88, HSIZE_WORD, 32'h0);
    run_seq(9);
    for (int i = 1; i < 8; i += 2) begin
      if (i == 5) continue;
      total++;
      if (ob_waits[i] !== 0) $display("FAIL busy_waits[%0d]: got %0d want 0", i, ob_waits[i]);
      else passed++;
      total++;
      if (ob_resp[i] !== 1'b0) $display("FAIL busy_resp[%0d]: got %b want 0", i, ob_resp[i]);
      else passed++;
    end
    total++;
    if (ob_waits[2] !== 2) $display("FAIL busy_beat_waits: got %0d want 2", ob_waits[2]);
    else passed++;
    total++;
    if (ob_rdata[5] !== 32'hB0B0_0001) $display("FAIL busy_rd0: got %h want b0b00001", ob_rdata[5]);
    else passed++;
    total++;
    if (ob_rdata[6] !== 32'hB0B0_0002) $display("FAIL busy_rd1: got %h want b0b00002", ob_rdata[6]);
    else passed++;
    total++;
    if (ob_rdata[8] !== 32'hB0B0_0003) $display("FAIL busy_rd2: got %h want b0b00003", ob_rdata[8]);
    else passed++;
    idle_cycles(1);
  endtask

  task automatic test_reset_in_wait();
    sel = 2'd2;
    HBURST = HBURST_SINGLE;
    set_item(0, HTRANS_NONSEQ, 1'b1, 32'h60, HSIZE_WORD, 32'h0BAD_F00D);
    run_seq(1);
    total++;
    if (ob_waits[0] !== 3) $display("FAIL ws3_waits: got %0d want 3", ob_waits[0]);
    else passed++;
    HTRANS = HTRANS_NONSEQ;
    HADDR  = 32'h60;
    HWRITE = 1'b1;
    HSIZE  = HSIZE_WORD;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_IDLE;
    HWDATA = 32'hFFFF_FFFF;
    total++;
    if (ready_v[2] !== 1'b0) $display("FAIL rst_pre_wait: got %b want 0", ready_v[2]);
    else passed++;
    @(posedge HCLK); #3;
    HRESETn = 1'b0;
    #1;
    total++;
    if (ready_v[2] !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_v[2]);
    else passed++;
    total++;
    if (resp_v[2] !== 1'b0) $display("FAIL rst_resp: got %b want 0", resp_v[2]);
    else passed++;
    total++;
    if (rdata_v[2] !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rdata_v[2]);
    else passed++;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    idle_cycles(1);
    set_item(0, HTRANS_NONSEQ, 1'b0, 32'h60, HSIZE_WORD, 32'h0);
    run_seq(1);
    total++;
    if (ob_rdata[0] !== 32'h0BAD_F00D)
      $display("FAIL rst_no_commit: got %h want 0badf00d", ob_rdata[0]);
    else passed++;
  endtask

  initial begin
    HRESETn  = 1'b0;
    hsel_bus = 1'b0;
    sel      = 2'd0;
    HADDR    = 32'h0;
    HTRANS   = HTRANS_IDLE;
    HWRITE   = 1'b0;
    HSIZE    = HSIZE_WORD;
    HBURST   = HBURST_SINGLE;
    HWDATA   = 32'h0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait_burst();
    test_error();
    test_busy();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
